// File: rtl/arb4_rr.sv
// arb4_rr: 4-way round-robin arbiter with per-owner hold limit; grants registered, 1-cycle latency.
// Define ARB4_LOCK_EN to add the lock input that lets the owner suppress the hold-limit release.
module arb4_rr #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef ARB4_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic          r_busy, w_busy_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_last, w_last_nxt;

  logic [3:0]    w_pend;
  logic          w_found;
  logic [1:0]    w_win;
  logic          w_owner_req;
  logic          w_lock_hold;
  logic          w_release;
  logic          w_new_grant;

  // In IDLE r_gnt is zero, so the same masked search serves both states.
  assign w_pend      = req & ~r_gnt;
  assign w_owner_req = |(req & r_gnt);

`ifdef ARB4_LOCK_EN
  assign w_lock_hold = lock & w_owner_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  // Descending scan so the candidate closest after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int i = 4; i >= 1; i--) begin
      if (w_pend[2'(int'(r_last) + i)]) begin
        w_found = 1'b1;
        w_win   = 2'(int'(r_last) + i);
      end
    end
  end

  assign w_release = !w_owner_req || ((r_cnt == HOLD_MAX) && w_found && !w_lock_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release && !w_found) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_new_grant = w_found && ((r_state == S_IDLE) || w_release);

  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_sel_nxt  = r_sel;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    w_busy_nxt = (w_state_nxt == S_GRANT);
    if (w_new_grant) begin
      w_gnt_nxt  = 4'b0001 << w_win;
      w_sel_nxt  = w_win;
      w_cnt_nxt  = '0;
      w_last_nxt = w_win;
    end else if (w_state_nxt == S_IDLE) begin
      w_gnt_nxt = 4'b0000;
      w_cnt_nxt = '0;
    end else if (r_cnt != HOLD_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed-vector bench for arb4_rr (MAX_HOLD=4); lock scenario runs when ARB4_LOCK_EN is defined.
module tb_arb4_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
`ifdef ARB4_LOCK_EN
  logic       lock;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  arb4_rr #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef ARB4_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    chk({nm, ".gnt"}, idx, gnt, eg);
    chk({nm, ".sel"}, idx, {2'b00, sel}, {2'b00, es});
    chk({nm, ".busy"}, idx, {3'b000, busy}, {3'b000, eb});
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.req = r; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Two requesters alternate every 4 cycles.
    for (int i = 0; i < 4; i++) add(4'b0101, 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b0101, 4'b0100, 2'd2, 1'b1);
    add(4'b0101, 4'b0001, 2'd0, 1'b1);
    add(4'b0101, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // Lone requester keeps the grant past saturation; sel holds in IDLE.
    for (int i = 0; i < 10; i++) add(4'b0010, 4'b0010, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, 2'd1, 1'b0);
    add(4'b0000, 4'b0000, 2'd1, 1'b0);
    // Owner drop hands straight over with no bubble.
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b1001, 4'b0001, 2'd0, 1'b1);
    add(4'b1000, 4'b1000, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, 2'd3, 1'b0);
    // All requesting: 0,1,2,3,0 with 4 cycles each.
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++) add(4'b1111, 4'b0001 << g, 2'(g), 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 1'b1);

    rst_n = 1'b0;
    req   = 4'b0000;
`ifdef ARB4_LOCK_EN
    lock  = 1'b0;
`endif
    #1;
    chk_all("reset", 0, 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_clk", 0, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      step(vecs[k].req);
      chk_all("vec", k, vecs[k].gnt, vecs[k].sel, vecs[k].busy);
    end

    // Asynchronous reset in the middle of a grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 4'b0000, 2'd0, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 0, 4'b1000, 2'd3, 1'b1);

    step(4'b0000);
    chk_all("idle2", 0, 4'b0000, 2'd3, 1'b0);
    step(4'b0100);
    chk_all("own2", 0, 4'b0100, 2'd2, 1'b1);
`ifdef ARB4_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(4'b0101);
      chk_all("lock_hold", i, 4'b0100, 2'd2, 1'b1);
    end
    lock = 1'b0;
    step(4'b0101);
    chk_all("lock_drop", 0, 4'b0001, 2'd0, 1'b1);
`else
    for (int i = 0; i < 3; i++) begin
      step(4'b0101);
      chk_all("own2_hold", i, 4'b0100, 2'd2, 1'b1);
    end
    step(4'b0101);
    chk_all("own2_timeout", 0, 4'b0001, 2'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles one requester keeps while others wait (legal 2..256).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  input  4  request per requester; bit i is requester i; level-sensitive.
REQ-005 SHALL have port lock  input  1  current owner asks to hold past MAX_HOLD; present only with ARB4_LOCK_EN.
REQ-006 SHALL have port gnt  output  4  registered one-hot grant, or all-zero.
REQ-007 SHALL have port sel  output  2  registered binary index of the owner; drives the shared 4:1 mux select.
REQ-008 SHALL have port busy  output  1  registered; 1 while any gnt bit is 1.

Function
REQ-009 SHALL implement two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-010 SHALL, in IDLE with req!=0, select the winner round-robin, searching from index last+1 mod 4, where last is the most recent owner; gnt, sel and busy update on the next edge (1-cycle request-to-grant latency).
REQ-011 SHALL, in IDLE with req==0, stay in IDLE with sel holding its previous value.
REQ-012 SHALL keep a hold counter, cleared on every new grant and incremented each GRANT cycle, saturating at MAX_HOLD-1.
REQ-013 SHALL release the owner when req[owner]==0, or when the counter equals MAX_HOLD-1 and another req bit is 1.
REQ-014 SHALL, on release with another requester pending, grant the round-robin winner (search from owner+1, owner excluded) on the same edge, with no idle bubble.
REQ-015 SHALL, on release with no other requester pending, go to IDLE; gnt=0 and busy=0 on the next edge.
REQ-016 SHALL keep the grant while req[owner]==1 and no other requester is pending, even at counter saturation.
REQ-017 SHALL update last to the owner index at each grant; sel SHALL always equal the encoding of the set gnt bit while busy=1.
REQ-018 SHALL never present more than one gnt bit set, and SHALL never change gnt combinationally from req.

Reset
REQ-019 SHALL, on rst_n=0 and independently of clk, force state IDLE, gnt=4'b0000, sel=2'b00, busy=0, counter=0, last=3 (requester 0 has first priority).
REQ-020 SHALL, on reset asserted mid-grant, drop gnt immediately; after deassertion, arbitration restarts per REQ-010 on the first clock edge.

Configuration
REQ-021 SHALL recognise macro ARB4_LOCK_EN.
REQ-022 SHALL, with ARB4_LOCK_EN defined, provide port lock; while lock=1 and req[owner]=1, the timeout release of REQ-013 is suppressed; release on req[owner]==0 is unaffected.
REQ-023 SHALL, without ARB4_LOCK_EN, omit port lock and always enforce the timeout.

Verification (MAX_HOLD=4)
REQ-024 SHALL cover: reset, then req=4'b0101 held -> gnt=0001 one cycle later; after 4 cycles gnt=0100, sel=2; after 4 more cycles gnt=0001.
REQ-025 SHALL cover: req=4'b0010 alone for 10 cycles -> gnt=0010 throughout, sel=1, busy=1; req drops -> gnt=0000 next edge.
REQ-026 SHALL cover: owner 0 drops req while req[3]=1 -> gnt goes 0001->1000 on one edge, with no all-zero cycle.
REQ-027 SHALL cover: req=4'b1111 continuously -> grant order 0,1,2,3,0, with 4 cycles each.
REQ-028 SHALL cover: rst_n pulsed low mid-grant asynchronously -> gnt=0, sel=0, busy=0 before the next clk edge; with req=4'b1000 held -> gnt=1000 on the first edge after release.
REQ-029 SHALL cover (ARB4_LOCK_EN): owner 2 with lock=1 and req[0]=1 pending -> gnt=0100 held for 8 cycles; lock drops -> gnt=0001 on the next edge.
